// File: rtl/pm_bus_pkg.sv
// Shared CPU-bus definitions for the keypad block: register addresses,
// key bit indices and the debounce threshold reset value.
package pm_bus_pkg;

   localparam logic [23:0] KEY_EDGE_ADDR = 24'h002050;
   localparam logic [23:0] KEY_DBNC_ADDR = 24'h002051;
   localparam logic [23:0] KEY_PAD_ADDR  = 24'h002052;

   localparam logic [7:0]  KEY_DBNC_RST  = 8'h04;
   localparam int          NUM_KEYS      = 8;

   typedef enum logic [2:0] {
      KEY_A     = 3'd0,
      KEY_B     = 3'd1,
      KEY_C     = 3'd2,
      KEY_UP    = 3'd3,
      KEY_DOWN  = 3'd4,
      KEY_LEFT  = 3'd5,
      KEY_RIGHT = 3'd6,
      KEY_POWER = 3'd7
   } key_idx_e;

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, tick-driven debounce counter, stable bit
// and press/release edge flags. Optional host override: KEYPAD_OVERRIDE_EN.
module key_debounce #(
   parameter int DBNC_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_n,
   input  logic              tick,
   input  logic [DBNC_W-1:0] thr,
`ifdef KEYPAD_OVERRIDE_EN
   input  logic              ovr_en,
   input  logic              ovr_n,
`endif
   output logic              stable,
   output logic              rise,
   output logic              fall
);

   logic              sync1_r;
   logic              sync2_r;
   logic              stable_r;
   logic              stable_d_r;
   logic [DBNC_W-1:0] cnt_r;
   logic [DBNC_W-1:0] cnt_nxt_s;
   logic              dbnc_stable_s;
   logic              stable_nxt_s;
   logic [DBNC_W:0]   cnt_inc_s;

   // One extra bit so the compare and saturation see a carry out of all-ones.
   assign cnt_inc_s = {1'b0, cnt_r} + {{DBNC_W{1'b0}}, 1'b1};

   // Debounce decision: clear on agreement, bypass on thr==0, count on ticks.
   always_comb begin
      dbnc_stable_s = stable_r;
      cnt_nxt_s     = cnt_r;
      if (sync2_r == stable_r) begin
         cnt_nxt_s = {DBNC_W{1'b0}};
      end else if (thr == {DBNC_W{1'b0}}) begin
         dbnc_stable_s = sync2_r;
         cnt_nxt_s     = {DBNC_W{1'b0}};
      end else if (tick) begin
         if (cnt_inc_s >= {1'b0, thr}) begin
            dbnc_stable_s = sync2_r;
            cnt_nxt_s     = {DBNC_W{1'b0}};
         end else if (cnt_inc_s[DBNC_W]) begin
            cnt_nxt_s = cnt_r;
         end else begin
            cnt_nxt_s = cnt_inc_s[DBNC_W-1:0];
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

`ifdef KEYPAD_OVERRIDE_EN
   assign stable_nxt_s = ovr_en ? ovr_n : dbnc_stable_s;
`else
   assign stable_nxt_s = dbnc_stable_s;
`endif

   // Synchronizer, counter and stable/previous-stable state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r    <= 1'b1;
         sync2_r    <= 1'b1;
         stable_r   <= 1'b1;
         stable_d_r <= 1'b1;
         cnt_r      <= {DBNC_W{1'b0}};
      end else begin
         sync1_r    <= key_n;
         sync2_r    <= sync1_r;
         stable_r   <= stable_nxt_s;
         stable_d_r <= stable_r;
         cnt_r      <= cnt_nxt_s;
      end
   end

   assign stable = stable_r;
   assign fall   = stable_d_r & ~stable_r;
   assign rise   = ~stable_d_r & stable_r;

endmodule

// File: rtl/keypad.sv
// Keypad block: eight debounced buttons, KEY_EDGE/KEY_DBNC/KEY_PAD registers
// at $2050-$2052, per-key irq pulses. Optional host override: KEYPAD_OVERRIDE_EN.
module keypad
   import pm_bus_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DBNC_W  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_write,
   input  logic        bus_read,
   input  logic [23:0] bus_address_in,
   input  logic [7:0]  bus_data_in,
   output logic [7:0]  bus_data_out,
   input  logic [7:0]  keys_n,
`ifdef KEYPAD_OVERRIDE_EN
   input  logic        key_override_en,
   input  logic [7:0]  key_override_n,
`endif
   output logic [7:0]  irq_keys
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PRE_W-1:0]  pre_cnt_r;
   logic              tick_s;
   logic [7:0]        key_edge_r;
   logic [DBNC_W-1:0] thr_r;
   logic [7:0]        irq_keys_r;
   logic [7:0]        stable_s;
   logic [7:0]        rise_s;
   logic [7:0]        fall_s;
   logic [7:0]        dbnc_rd_s;
   logic              wr_edge_s;
   logic              wr_dbnc_s;
   logic              unused_bus_read_s;

   // Reads have no side effects, so the read strobe is deliberately ignored.
   assign unused_bus_read_s = bus_read;

   assign tick_s    = (pre_cnt_r == PRE_W'(CLK_DIV - 1));
   assign wr_edge_s = bus_write && (bus_address_in == KEY_EDGE_ADDR);
   assign wr_dbnc_s = bus_write && (bus_address_in == KEY_DBNC_ADDR);

   // Debounce tick prescaler.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_r <= {PRE_W{1'b0}};
      end else if (tick_s) begin
         pre_cnt_r <= {PRE_W{1'b0}};
      end else begin
         pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end
   end

   // Software-visible configuration registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_edge_r <= 8'h00;
         thr_r      <= KEY_DBNC_RST[DBNC_W-1:0];
      end else begin
         if (wr_edge_s) begin
            key_edge_r <= bus_data_in;
         end
         if (wr_dbnc_s) begin
            thr_r <= bus_data_in[DBNC_W-1:0];
         end
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DBNC_W (DBNC_W)
      ) u_dbnc (
         .clk    (clk),
         .reset  (reset),
         .key_n  (keys_n[i]),
         .tick   (tick_s),
         .thr    (thr_r),
`ifdef KEYPAD_OVERRIDE_EN
         .ovr_en (key_override_en),
         .ovr_n  (key_override_n[i]),
`endif
         .stable (stable_s[i]),
         .rise   (rise_s[i]),
         .fall   (fall_s[i])
      );
   end

   // Edge select uses the KEY_EDGE value held before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_keys_r <= 8'h00;
      end else begin
         irq_keys_r <= (key_edge_r & rise_s) | (~key_edge_r & fall_s);
      end
   end

   assign irq_keys = irq_keys_r;

   // Combinational read mux; threshold is zero-extended to the bus width.
   always_comb begin
      dbnc_rd_s               = 8'h00;
      dbnc_rd_s[DBNC_W-1:0]   = thr_r;
      case (bus_address_in)
         KEY_EDGE_ADDR: bus_data_out = key_edge_r;
         KEY_DBNC_ADDR: bus_data_out = dbnc_rd_s;
         KEY_PAD_ADDR:  bus_data_out = stable_s;
         default:       bus_data_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_keypad.sv
// Directed self-checking bench for keypad (CLK_DIV = 4, default threshold 4).
module tb_keypad;
   import pm_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_write;
   logic        bus_read;
   logic [23:0] bus_address_in;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out;
   logic [7:0]  keys_n;
   logic [7:0]  irq_keys;

   int n_assert = 0;
   int n_fail   = 0;
   int irq_seen [8] = '{default: 0};
   int base_a;
   int base_b;
   int base_c;
   int base_down;
   int base_left;
   int lat;
   logic pad_ok;

   keypad #(.CLK_DIV(4), .DBNC_W(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus_write      (bus_write),
      .bus_read       (bus_read),
      .bus_address_in (bus_address_in),
      .bus_data_in    (bus_data_in),
      .bus_data_out   (bus_data_out),
      .keys_n         (keys_n),
`ifdef KEYPAD_OVERRIDE_EN
      .key_override_en(1'b0),
      .key_override_n (8'hFF),
`endif
      .irq_keys       (irq_keys)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (irq_keys[i] === 1'b1) irq_seen[i]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [23:0] addr, input logic [7:0] data);
      bus_write      = 1'b1;
      bus_address_in = addr;
      bus_data_in    = data;
      @(posedge clk);
      #1;
      bus_write      = 1'b0;
      bus_address_in = KEY_PAD_ADDR;
   endtask

   task automatic rd_chk(input string tag, input logic [23:0] addr, input logic [7:0] exp);
      bus_address_in = addr;
      #1;
      chk(tag, {24'h0, bus_data_out}, {24'h0, exp});
      bus_address_in = KEY_PAD_ADDR;
   endtask

   task automatic wait_pad(input logic [7:0] exp, input int max, output int cyc);
      cyc = 0;
      bus_address_in = KEY_PAD_ADDR;
      while (cyc < max && bus_data_out !== exp) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus_write      = 1'b0;
      bus_read       = 1'b0;
      bus_address_in = KEY_PAD_ADDR;
      bus_data_in    = 8'h00;
      keys_n         = 8'hFF;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      rd_chk("rst_key_edge", KEY_EDGE_ADDR, 8'h00);
      rd_chk("rst_key_dbnc", KEY_DBNC_ADDR, 8'h04);
      rd_chk("rst_key_pad",  KEY_PAD_ADDR,  8'hFF);
      rd_chk("rst_other",    24'h002053,    8'h00);
      chk("rst_irq", {24'h0, irq_keys}, 32'h0);

      // Press A: 15..18 cycle latency, single press pulse
      base_a = irq_seen[KEY_A];
      keys_n[KEY_A] = 1'b0;
      wait_pad(8'hFE, 30, lat);
      chk("press_a_pad", {24'h0, bus_data_out}, 32'hFE);
      chk("press_a_lat_window", {31'h0, (lat >= 15 && lat <= 18)}, 32'h1);
      chk("press_a_no_early_irq", {24'h0, irq_keys}, 32'h0);
      @(posedge clk); #1;
      chk("press_a_irq", {24'h0, irq_keys}, 32'h01);
      @(posedge clk); #1;
      chk("press_a_irq_end", {24'h0, irq_keys}, 32'h00);
      keys_n[KEY_A] = 1'b1;
      wait_pad(8'hFF, 30, lat);
      chk("release_a_pad", {24'h0, bus_data_out}, 32'hFF);
      repeat (3) @(posedge clk); #1;
      chk("a_pulse_count", irq_seen[KEY_A] - base_a, 32'd1);

      // Release-edge selection on Down
      bus_wr(KEY_EDGE_ADDR, 8'h10);
      rd_chk("key_edge_rb", KEY_EDGE_ADDR, 8'h10);
      base_down = irq_seen[KEY_DOWN];
      keys_n[KEY_DOWN] = 1'b0;
      wait_pad(8'hEF, 30, lat);
      chk("press_down_pad", {24'h0, bus_data_out}, 32'hEF);
      repeat (3) @(posedge clk); #1;
      chk("press_down_no_irq", irq_seen[KEY_DOWN] - base_down, 32'd0);
      keys_n[KEY_DOWN] = 1'b1;
      wait_pad(8'hFF, 30, lat);
      chk("release_down_pad", {24'h0, bus_data_out}, 32'hFF);
      @(posedge clk); #1;
      chk("release_down_irq", {24'h0, irq_keys}, 32'h10);
      @(posedge clk); #1;
      chk("release_down_irq_end", {24'h0, irq_keys}, 32'h00);
      chk("down_pulse_count", irq_seen[KEY_DOWN] - base_down, 32'd1);

      // Six-cycle glitch on C is filtered
      base_c = irq_seen[KEY_C];
      pad_ok = 1'b1;
      keys_n[KEY_C] = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus_data_out !== 8'hFF) pad_ok = 1'b0;
      end
      keys_n[KEY_C] = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus_data_out !== 8'hFF) pad_ok = 1'b0;
      end
      chk("glitch_pad_steady", {31'h0, pad_ok}, 32'h1);
      chk("glitch_no_irq", irq_seen[KEY_C] - base_c, 32'd0);

      // Bypass (thr = 0): Left follows 3 cycles after raw edge
      bus_wr(KEY_DBNC_ADDR, 8'h00);
      rd_chk("key_dbnc_zero_rb", KEY_DBNC_ADDR, 8'h00);
      base_left = irq_seen[KEY_LEFT];
      keys_n[KEY_LEFT] = 1'b0;
      @(posedge clk); #1;
      chk("bypass_cyc1", {24'h0, bus_data_out}, 32'hFF);
      @(posedge clk); #1;
      chk("bypass_cyc2", {24'h0, bus_data_out}, 32'hFF);
      @(posedge clk); #1;
      chk("bypass_cyc3", {24'h0, bus_data_out}, 32'hDF);
      @(posedge clk); #1;
      chk("bypass_irq", {24'h0, irq_keys}, 32'h20);
      keys_n[KEY_LEFT] = 1'b1;
      repeat (6) @(posedge clk); #1;
      chk("bypass_release_pad", {24'h0, bus_data_out}, 32'hFF);
      chk("bypass_pulse_count", irq_seen[KEY_LEFT] - base_left, 32'd1);

      // A+B pressed, reset mid-debounce, full debounce after reset
      bus_wr(KEY_DBNC_ADDR, 8'h04);
      keys_n[KEY_A] = 1'b0;
      keys_n[KEY_B] = 1'b0;
      repeat (8) @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("mid_rst_pad", {24'h0, bus_data_out}, 32'hFF);
      chk("mid_rst_irq", {24'h0, irq_keys}, 32'h00);
      rd_chk("mid_rst_key_edge", KEY_EDGE_ADDR, 8'h00);
      reset  = 1'b0;
      base_a = irq_seen[KEY_A];
      base_b = irq_seen[KEY_B];
      @(posedge clk); #1;
      chk("post_rst_irq", {24'h0, irq_keys}, 32'h00);
      wait_pad(8'hFC, 30, lat);
      chk("post_rst_pad", {24'h0, bus_data_out}, 32'hFC);
      chk("post_rst_lat_window", {31'h0, (lat >= 14 && lat <= 17)}, 32'h1);
      chk("post_rst_no_early_irq", irq_seen[KEY_A] - base_a, 32'd0);
      @(posedge clk); #1;
      chk("post_rst_irq_ab", {24'h0, irq_keys}, 32'h03);
      @(posedge clk); #1;
      chk("post_rst_irq_end", {24'h0, irq_keys}, 32'h00);
      chk("post_rst_b_count", irq_seen[KEY_B] - base_b, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad.md
Name: keypad

Overview:
- Debounces the eight raw button inputs and presents the debounced state on the CPU bus at $2052.
- Produces one-cycle edge pulses, one per key, that feed the key group (K0x) inputs of the interrupt controller.
- Press or release edge selection is per key and software-programmable.
- Sits between the top-level button pins and the interrupt controller's `irqs[28:21]` inputs.

Parameters:
- CLK_DIV, 4, clk cycles per debounce tick (≥1).
- DBNC_W, 4, width of each per-key debounce counter and of the threshold field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bus_write  in  1  CPU write strobe
- bus_read  in  1  CPU read strobe (unused for side effects)
- bus_address_in  in  24  CPU address
- bus_data_in  in  8  CPU write data
- bus_data_out  out  8  read data, combinational
- keys_n  in  8  raw asynchronous buttons, active-low; bit order 0 A, 1 B, 2 C, 3 Up, 4 Down, 5 Left, 6 Right, 7 Power
- irq_keys  out  8  per-key one-cycle interrupt pulses, same bit order

Behaviour:
- Clock and reset: already decided — reset reset, synchronous, active-high; clock clk. All flops are on posedge clk.
- Registers:
  - $2050 KEY_EDGE (RW): per key, 0 = irq on press, 1 = irq on release. Reset value 8'h00.
  - $2051 KEY_DBNC (RW): [DBNC_W-1:0] = threshold in ticks; upper bits read 0. Reset value 4'd4.
  - $2052 KEY_PAD (RO): debounced state, active-low. Reset value 8'hFF. Writes are ignored.
  - Writes take effect on the posedge where `bus_write` is high and the address matches.
- Read mux: `bus_data_out` shows the addressed register, and 8'h00 for any other address.
- Synchronizer: two flops per key, reset to 1.
- Prescaler:
  - counter 0..CLK_DIV-1; `tick` is high for one cycle when it wraps.
  - Reset value 0.
- Per key i, every cycle:
  - If `sync[i] == stable[i]`: `cnt[i] <= 0`.
  - Else, on a tick: if `cnt[i] + 1 >= thr`, then `stable[i] <= sync[i]` and `cnt[i] <= 0`; otherwise `cnt[i] <= cnt[i] + 1`.
  - `cnt` saturates at all-ones; it never wraps.
  - thr == 0 means bypass: `stable[i] <= sync[i]` every cycle with no tick needed.
- Edge detection:
  - `fall[i]` = stable 1→0 (press); `rise[i]` = 0→1 (release).
  - `irq_keys[i]` is registered, high for exactly one cycle after the stable change when `(KEY_EDGE[i] ? rise : fall)`.
  - Reset value of `irq_keys` is 0.
- Latency (thr = T ≥ 1):
  - stable changes between 2 + (T-1)·CLK_DIV + 1 and 2 + T·CLK_DIV cycles after the raw edge.
  - `irq_keys` follows one cycle later.
- A bounce (sync returns to stable) before the threshold is reached clears `cnt`; no stable change, no irq.
- Writing KEY_DBNC mid-count keeps `cnt`; the `>=` compare against the new threshold applies from the next tick. A lowered threshold may therefore fire on the next tick.
- Writing KEY_EDGE in the same cycle as an edge: the pulse uses the old KEY_EDGE value (registered compare).
- Several keys changing at once produce simultaneous pulses on their bits.
- Reset mid-operation:
  - all counters are cleared and `stable` is set to 8'hFF;
  - no pulse is emitted on the cycle reset deasserts, even if keys are held;
  - a key held through reset produces a press pulse after a full debounce.

Optional Feature:
- Macro: KEYPAD_OVERRIDE_EN.
- When defined, adds ports `key_override_en` (in, 1) and `key_override_n` (in, 8), driven from the host for TAS/replay.
  - While `key_override_en` is high, `stable` is loaded directly from `key_override_n` each cycle, bypassing sync and debounce.
  - Edge detection and irq generation are unchanged.
- When undefined: ports absent; behaviour exactly as above.

Decomposition:
- Shared package `pm_bus_pkg`:
  - address constants KEY_EDGE_ADDR = 24'h2050, KEY_DBNC_ADDR = 24'h2051, KEY_PAD_ADDR = 24'h2052;
  - the key bit-index enum (KEY_A..KEY_POWER);
  - the KEY_DBNC reset constant.
- One sub-module `key_debounce`: a single key (synchronizer, counter, stable bit, rise/fall), instantiated 8× with a shared `tick` and `thr`.

Test Plan (CLK_DIV = 4, default thr = 4):
- Reset, then read $2050/$2051/$2052 → 8'h00 / 8'h04 / 8'hFF; `irq_keys` = 0.
- Drive `keys_n[0]` low and hold → KEY_PAD bit0 = 0 within 15..18 cycles; `irq_keys` = 8'h01 for exactly one cycle; release with KEY_EDGE = 0 → no pulse.
- Write KEY_EDGE = 8'h10, press then release Down → no pulse on press; `irq_keys` = 8'h10 once after release debounce.
- Glitch `keys_n[2]` low for 6 cycles, then high → KEY_PAD stays 8'hFF; no irq.
- Write KEY_DBNC = 0, toggle `keys_n[5]` → KEY_PAD bit5 follows 3 cycles after the raw edge; pulse on press.
- Press A and B on the same cycle, assert reset mid-debounce, hold keys → no pulse during or just after reset; then `irq_keys` = 8'h03 once after a full debounce.
